// File: rtl/ahb_lite_mem_slave.sv
// AHB-lite word-addressed memory responder with configurable wait states and a
// two-cycle ERROR response for misaligned or out-of-range addresses.
//   HCLK, HRESET       : clock, asynchronous active-high reset
//   HSEL, HADDR, HWRITE,
//   HTRANS, HREADY     : address phase (accepted when HSEL & HREADY & HTRANS[1])
//   HWDATA             : write data, sampled in the DONE (completion) cycle
//   HRDATA             : registered read data, loaded on entering DONE
//   HREADYOUT, HRESP   : registered response, a pure function of the state
module ahb_lite_mem_slave #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic          accept, legal;
  logic [31:0]   rdata_d;
  logic          hreadyout_d;
  logic [1:0]    hresp_d;
  logic [31:0]   mem [MEM_DEPTH];

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which this target treats alike
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign accept = HSEL & HREADY & HTRANS[1];
  assign legal  = (HADDR[1:0] == 2'b00) && (HADDR[31:2] < 30'(MEM_DEPTH));

  // Next state, captured transfer attributes and next registered outputs
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx_q;
    wr_d    = wr_q;
    rdata_d = HRDATA;
    unique case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d = HADDR[AW+1:2];
          wr_d  = HWRITE;
          if (!legal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt - CW'(1);
        if (cnt <= CW'(1)) state_d = S_DONE;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Zero-wait read hitting the word a completing write is about to update
    if (state_d == S_DONE && !wr_d) begin
      if (state == S_DONE && wr_q && idx_d == idx_q) rdata_d = HWDATA;
      else                                           rdata_d = mem[idx_d];
    end

    hreadyout_d = !(state_d == S_WAIT || state_d == S_ERR1);
    hresp_d     = (state_d == S_ERR1 || state_d == S_ERR2) ? 2'b01 : 2'b00;
  end

  // State and output registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      HRDATA    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 2'b00;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      HRDATA    <= rdata_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
    end
  end

  // Write commits on the edge leaving DONE; reset forces IDLE so it abandons it
  always_ff @(posedge HCLK) begin
    if (state == S_DONE && wr_q) mem[idx_q] <= HWDATA;
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
module tb_ahb_lite_mem_slave;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // Zero-wait instance
  logic        rst0, sel0, wr0, rdy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [1:0]  trans0, resp0;

  // Three-wait-state instance
  logic        rst3, sel3, wr3, rdy3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [1:0]  trans3, resp3;

  ahb_lite_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESET(rst0), .HSEL(sel0), .HADDR(addr0), .HWRITE(wr0),
    .HTRANS(trans0), .HWDATA(wdata0), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_lite_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) u3 (
    .HCLK(HCLK), .HRESET(rst3), .HSEL(sel3), .HADDR(addr3), .HWRITE(wr3),
    .HTRANS(trans3), .HWDATA(wdata3), .HREADY(rdy3),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle0();
    sel0 = 1'b0; trans0 = 2'b00; wr0 = 1'b0; addr0 = '0;
  endtask

  task automatic idle3();
    sel3 = 1'b0; trans3 = 2'b00; wr3 = 1'b0; addr3 = '0;
  endtask

  task automatic w0_write(input logic [31:0] a, input logic [31:0] d);
    sel0 = 1'b1; addr0 = a; wr0 = 1'b1; trans0 = 2'b10;
    cyc();
    idle0(); wdata0 = d;
    cyc();
  endtask

  // Waits (bounded) for the DONE cycle of a u3 transfer already accepted
  task automatic wait3_done(input string name);
    int n = 0;
    while (rdy3 !== 1'b1 && n < 20) begin cyc(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL %s_timeout cycles=%0d limit=20", name, n); end
  endtask

  task automatic w3_write(input logic [31:0] a, input logic [31:0] d);
    sel3 = 1'b1; addr3 = a; wr3 = 1'b1; trans3 = 2'b10;
    cyc();
    idle3(); wdata3 = d;
    wait3_done("w3_write");
    cyc();
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1; idle0(); idle3(); wdata0 = '0; wdata3 = '0;
    repeat (3) cyc();
    rst0 = 1'b0; rst3 = 1'b0;
    cyc();
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_u0_ready got=%b exp=1", rdy0); end
    checks++; if (resp0 !== 2'b00) begin errors++; $display("FAIL rst_u0_resp got=%b exp=00", resp0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rst_u0_rdata got=%h exp=0", rdata0); end
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL rst_u3_ready got=%b exp=1", rdy3); end
    checks++; if (resp3 !== 2'b00) begin errors++; $display("FAIL rst_u3_resp got=%b exp=00", resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rst_u3_rdata got=%h exp=0", rdata3); end
  endtask

  task automatic test_write_read();
    sel0 = 1'b1; addr0 = 32'h10; wr0 = 1'b1; trans0 = 2'b10;
    cyc();
    checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin errors++; $display("FAIL wr_done got=%b/%b exp=1/00", rdy0, resp0); end
    wdata0 = 32'hDEADBEEF; idle0();
    cyc();
    sel0 = 1'b1; addr0 = 32'h10; wr0 = 1'b0; trans0 = 2'b10;
    cyc();
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rdata0); end
    checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin errors++; $display("FAIL rd_done got=%b/%b exp=1/00", rdy0, resp0); end
    idle0();
    cyc();
  endtask

  task automatic test_back_to_back();
    w0_write(32'h24, 32'hCAFEF00D);
    w0_write(32'h20, 32'h0BADBAD0);
    sel0 = 1'b1; addr0 = 32'h20; wr0 = 1'b1; trans0 = 2'b10;
    cyc();
    wdata0 = 32'h12345678; addr0 = 32'h20; wr0 = 1'b0; trans0 = 2'b10;
    cyc();
    checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL b2b_forward got=%h exp=12345678", rdata0); end
    addr0 = 32'h24; trans0 = 2'b11;
    cyc();
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_other got=%h exp=cafef00d", rdata0); end
    addr0 = 32'h20;
    cyc();
    checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL b2b_mem got=%h exp=12345678", rdata0); end
    idle0();
    cyc();
  endtask

  task automatic test_error();
    w0_write(32'h0, 32'h11111111);
    sel0 = 1'b1; addr0 = 32'h0; wr0 = 1'b0; trans0 = 2'b10;
    cyc();
    checks++; if (rdata0 !== 32'h11111111) begin errors++; $display("FAIL err_pre got=%h exp=11111111", rdata0); end
    addr0 = 32'h400; wr0 = 1'b1;
    cyc();
    checks++; if (rdy0 !== 1'b0 || resp0 !== 2'b01) begin errors++; $display("FAIL err_range_1 got=%b/%b exp=0/01", rdy0, resp0); end
    checks++; if (rdata0 !== 32'h11111111) begin errors++; $display("FAIL err_rdata_hold got=%h exp=11111111", rdata0); end
    wdata0 = 32'hFFFFFFFF; addr0 = 32'h02; wr0 = 1'b1;
    cyc();
    checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b01) begin errors++; $display("FAIL err_range_2 got=%b/%b exp=1/01", rdy0, resp0); end
    cyc();
    checks++; if (rdy0 !== 1'b0 || resp0 !== 2'b01) begin errors++; $display("FAIL err_misal_1 got=%b/%b exp=0/01", rdy0, resp0); end
    wdata0 = 32'hEEEEEEEE; addr0 = 32'h0; wr0 = 1'b0;
    cyc();
    checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b01) begin errors++; $display("FAIL err_misal_2 got=%b/%b exp=1/01", rdy0, resp0); end
    cyc();
    checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin errors++; $display("FAIL err_follow_resp got=%b/%b exp=1/00", rdy0, resp0); end
    checks++; if (rdata0 !== 32'h11111111) begin errors++; $display("FAIL err_mem_kept got=%h exp=11111111", rdata0); end
    idle0();
    cyc();
  endtask

  task automatic test_no_transfer();
    logic       sel_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] tr_v  [3] = '{2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      sel0 = sel_v[i]; trans0 = tr_v[i]; addr0 = 32'h0; wr0 = 1'b1;
      cyc();
      checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin errors++; $display("FAIL notx_%0d got=%b/%b exp=1/00", i, rdy0, resp0); end
      wdata0 = 32'h0BAD0000 + i;
    end
    idle0();
    cyc();
    sel0 = 1'b1; addr0 = 32'h0; wr0 = 1'b0; trans0 = 2'b10;
    cyc();
    checks++; if (rdata0 !== 32'h11111111) begin errors++; $display("FAIL notx_mem got=%h exp=11111111", rdata0); end
    idle0();
    cyc();
  endtask

  task automatic test_wait_states();
    w3_write(32'h0, 32'hA5A5A5A5);
    sel3 = 1'b1; addr3 = 32'h0; wr3 = 1'b0; trans3 = 2'b10;
    cyc();
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (rdy3 !== 1'b0 || resp3 !== 2'b00) begin errors++; $display("FAIL ws_wait_%0d_%0d got=%b/%b exp=0/00", rep, k, rdy3, resp3); end
        cyc();
      end
      checks++; if (rdy3 !== 1'b1 || resp3 !== 2'b00) begin errors++; $display("FAIL ws_done_%0d got=%b/%b exp=1/00", rep, rdy3, resp3); end
      checks++; if (rdata3 !== 32'hA5A5A5A5) begin errors++; $display("FAIL ws_data_%0d got=%h exp=a5a5a5a5", rep, rdata3); end
      if (rep == 1) idle3();
      cyc();
    end
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL ws_idle got=%b exp=1", rdy3); end
  endtask

  task automatic test_reset_mid_wait();
    w3_write(32'h8, 32'h55AA55AA);
    sel3 = 1'b1; addr3 = 32'h8; wr3 = 1'b0; trans3 = 2'b10;
    cyc();
    idle3();
    wait3_done("rmw_pre");
    checks++; if (rdata3 !== 32'h55AA55AA) begin errors++; $display("FAIL rmw_pre got=%h exp=55aa55aa", rdata3); end
    cyc();
    sel3 = 1'b1; addr3 = 32'h8; wr3 = 1'b1; trans3 = 2'b10;
    cyc();
    idle3(); wdata3 = 32'h99999999;
    cyc();
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL rmw_in_wait got=%b exp=0", rdy3); end
    #2 rst3 = 1'b1;
    #1;
    checks++; if (rdy3 !== 1'b1 || resp3 !== 2'b00) begin errors++; $display("FAIL rmw_async got=%b/%b exp=1/00", rdy3, resp3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rmw_rdata got=%h exp=0", rdata3); end
    repeat (2) cyc();
    rst3 = 1'b0;
    cyc();
    sel3 = 1'b1; addr3 = 32'h8; wr3 = 1'b0; trans3 = 2'b10;
    cyc();
    idle3();
    wait3_done("rmw_post");
    checks++; if (rdata3 !== 32'h55AA55AA) begin errors++; $display("FAIL rmw_mem_kept got=%h exp=55aa55aa", rdata3); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_error();
    test_no_transfer();
    test_wait_states();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-lite responder: a single-port word-addressed memory behind one HSEL.
- Other end of the team's AHB-lite master/driver interface. Sits on the bus as the target that the driver-side agent exercises.
- Supports a configurable number of wait states and a two-cycle ERROR response for illegal addresses.
- Single outstanding transfer, pipelined address/data phases.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words (power of two, 16..4096).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready (previous transfer done).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; HREADYOUT=1, HRESP=00, HRDATA=0, wait counter 0.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons it; no memory write occurs.
- Address phase accepted on a rising edge when HSEL & HREADY & HTRANS[1]. Capture addr, write flag, and legal flag.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no transfer; next state IDLE (zero-wait OKAY).
- Legal = HADDR[1:0]==0 and HADDR[31:2] < MEM_DEPTH. Word index = HADDR[31:2] truncated to log2(MEM_DEPTH) bits.
- States (outputs are registered and depend only on state):
  - IDLE: HREADYOUT=1, HRESP=00.
  - WAIT: HREADYOUT=0, HRESP=00. Counter loaded with WAIT_STATES on accept and decremented each cycle. Goes to DONE when the counter reaches 1.
  - DONE: HREADYOUT=1, HRESP=00; the OKAY completion cycle.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
- Transitions out of IDLE, DONE and ERR2 (cycles where the bus sees ready):
  - Accepted illegal transfer -> ERR1.
  - Accepted legal transfer with WAIT_STATES>0 -> WAIT.
  - Accepted legal transfer with WAIT_STATES=0 -> DONE.
  - Otherwise -> IDLE.
- Other transitions:
  - ERR1 -> ERR2 unconditionally.
  - No address phase is accepted in ERR1 or WAIT (HREADY low).
- Latency:
  - Legal transfer: WAIT_STATES+1 cycles from the address-phase edge to the completing edge.
  - Illegal transfer: 2 cycles.
- Read: HRDATA is loaded from mem[index] on the edge entering DONE. It holds its value in all other states; ERROR cycles leave HRDATA unchanged.
- Write:
  - mem[index] <= HWDATA on the edge leaving DONE (HWDATA sampled in the completion cycle).
  - Illegal addresses never write.
- Read-after-write hazard: a read accepted in a write's DONE cycle with WAIT_STATES=0 and the same index loads HRDATA from HWDATA (forwarding). A different index reads the memory normally.
- Back-to-back transfers in DONE/ERR2 are fully pipelined; no idle cycle is inserted.
- HWRITE/HWDATA on non-accepted cycles are ignored.

Test Plan:
- Reset then WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10. Write completes 1 cycle after its address phase; the read returns 0xDEADBEEF with HREADYOUT=1 and HRESP=00 exactly 1 cycle after its address phase.
- Back-to-back: NONSEQ write 0x20=0x12345678 immediately followed by read 0x20 (address phase in the write's DONE cycle). HRDATA=0x12345678 via forwarding; read 0x24 returns the prior memory value.
- WAIT_STATES=3: read 0x0. HREADYOUT=0 for 3 cycles, then 1 with data. Hold HTRANS=NONSEQ during waits; no second accept until HREADY=1.
- Illegal address HADDR=MEM_DEPTH*4 (0x400 at default) and misaligned 0x02 write. Required response: HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01. Memory is unchanged, and a following read in ERR2 completes with OKAY.
- HTRANS=IDLE and BUSY with HSEL=1, and NONSEQ with HSEL=0: HREADYOUT stays 1, HRESP=00, no memory change.
- HRESET asserted mid-WAIT of a write, asynchronously between edges: HREADYOUT=1, HRESP=00, HRDATA=0 immediately. The target word keeps its old value.
